dsp_test_harness: RTL and testbench
===================================

DSP_TEST_HARNESS -- requirements
Module: dsp_test_harness

Interface
REQ-001 Parameter SAMPLE_WIDTH, default 16: bits per captured DAC channel sample, signed.
REQ-002 Parameter CHANNELS, default 2: DAC channels captured per sample frame (1..8).
REQ-003 Parameter CAPTURE_DEPTH, default 64: sample-frame FIFO depth, power of two, at least 2.
REQ-004 Parameter WQ_DEPTH, default 8: register-write queue depth, power of two, at least 2.
REQ-005 One clock; reset is asynchronous and active-high; ports named clock and reset.
REQ-006 clock  in  1  system clock; all state on rising edge.
REQ-007 reset  in  1  asynchronous active-high reset.
REQ-008 host_wr_valid  in  1  host offers a DSP register write.
REQ-009 host_wr_addr  in  8  DSP register address of offered write.
REQ-010 host_wr_data  in  8  DSP register data of offered write.
REQ-011 host_wr_ready  out  1  write queue not full; valid&ready = accepted.
REQ-012 dsp_reg_address  out  8  address driven to DSP register port.
REQ-013 dsp_reg_data_in  out  8  data driven to DSP register port.
REQ-014 dsp_reg_write_enable  out  1  single-cycle DSP register write strobe.
REQ-015 dsp_idle  in  1  DSP idle flag; rising edge marks a completed sample frame.
REQ-016 dac_in  in  CHANNELS*SAMPLE_WIDTH  DAC outputs, channel 0 in LSBs.
REQ-017 capture_enable  in  1  enables sample-frame capture.
REQ-018 cap_rd_valid  out  1  capture FIFO non-empty.
REQ-019 cap_rd_data  out  CHANNELS*SAMPLE_WIDTH  oldest captured frame (show-ahead).
REQ-020 cap_rd_ready  in  1  host pops frame when cap_rd_valid high.
REQ-021 cap_count  out  clog2(CAPTURE_DEPTH)+1  frames currently held.
REQ-022 cap_overflow  out  1  sticky: a frame was dropped because FIFO full.
REQ-023 clear  in  1  synchronous flush of both queues and overflow flag.

Function
REQ-024 Write queue SHALL be FIFO-ordered; writes reach DSP in acceptance order, none lost or duplicated.
REQ-025 Apply FSM states WAIT and ISSUE; WAIT->ISSUE when queue non-empty and dsp_idle high; ISSUE pops one entry, drives strobe for exactly one cycle, returns to WAIT.
REQ-026 dsp_reg_write_enable SHALL be high only in cycles where dsp_idle is high; if dsp_idle falls while in WAIT, issue stalls.
REQ-027 At most one DSP write every 2 cycles; address/data valid in the strobe cycle, held until next issue.
REQ-028 Write accepted same cycle as queue becomes non-empty issues no earlier than next cycle (latency >= 1).
REQ-029 Simultaneous accept and pop on full queue: ready reflects pre-pop full state (ready low), no accept.
REQ-030 Frame capture SHALL occur on the cycle after dsp_idle rises (registered edge detect), sampling dac_in that cycle, only if capture_enable high.
REQ-031 Capture into full FIFO with no same-cycle pop: frame dropped, cap_overflow set; contents unchanged.
REQ-032 Capture and pop in same cycle on full FIFO: both occur, count unchanged, no overflow.
REQ-033 Pop on empty FIFO ignored; pointers wrap modulo depth; cap_count exact 0..CAPTURE_DEPTH.
REQ-034 clear has priority over push/pop/accept same cycle: queues emptied, overflow cleared, FSM to WAIT, no strobe.

Reset
REQ-035 On reset: both queues empty, FSM WAIT, host_wr_ready 1, dsp_reg_write_enable 0, dsp_reg_address 0, dsp_reg_data_in 0, cap_rd_valid 0, cap_count 0, cap_overflow 0, idle edge detector 0.
REQ-036 Reset mid-ISSUE SHALL drop the strobe immediately and discard queued writes.

Verification
REQ-037 dsp_idle=1, push (0x4C,0x01),(0x5C,0x00) -> strobes in order on separate cycles, two cycles apart, addresses 0x4C then 0x5C.
REQ-038 dsp_idle=0, push 8 writes -> no strobe, host_wr_ready 0 after 8th; raise dsp_idle -> 8 strobes in order, ready returns 1.
REQ-039 capture_enable=1, 3 idle rising edges with dac_in {0x1234,0xFEDC}... -> cap_count 3, frames read back in order, lsb channel 0x1234 first.
REQ-040 64 captures no pops, then 65th -> cap_count 64, cap_overflow 1, first frame preserved; full + simultaneous pop/capture -> count 64, FIFO advances.
REQ-041 Assert reset during strobe cycle with 3 queued -> strobe low asynchronously, queue empty, no further strobes after release.
REQ-042 clear with same-cycle host write and capture edge -> all empty, overflow 0, write not accepted.

Source files
------------

// File: rtl/dsp_test_harness.sv
// DSP test harness: queues host register writes into the DSP when it is idle,
// and captures one DAC frame per idle rising edge into a show-ahead FIFO.
module dsp_test_harness #(
    parameter int SAMPLE_WIDTH  = 16,
    parameter int CHANNELS      = 2,
    parameter int CAPTURE_DEPTH = 64,
    parameter int WQ_DEPTH      = 8
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 host_wr_valid,
    input  logic [7:0]                           host_wr_addr,
    input  logic [7:0]                           host_wr_data,
    output logic                                 host_wr_ready,
    output logic [7:0]                           dsp_reg_address,
    output logic [7:0]                           dsp_reg_data_in,
    output logic                                 dsp_reg_write_enable,
    input  logic                                 dsp_idle,
    input  logic [CHANNELS*SAMPLE_WIDTH-1:0]     dac_in,
    input  logic                                 capture_enable,
    output logic                                 cap_rd_valid,
    output logic [CHANNELS*SAMPLE_WIDTH-1:0]     cap_rd_data,
    input  logic                                 cap_rd_ready,
    output logic [$clog2(CAPTURE_DEPTH):0]       cap_count,
    output logic                                 cap_overflow,
    input  logic                                 clear
);

    localparam int FW  = CHANNELS * SAMPLE_WIDTH;
    localparam int CAW = $clog2(CAPTURE_DEPTH);
    localparam int WAW = $clog2(WQ_DEPTH);

    typedef enum logic {S_WAIT, S_ISSUE} state_t;

    // ---------------- register-write queue ----------------
    logic [15:0]    wq_mem [WQ_DEPTH];
    logic [WAW-1:0] wq_wr_q, wq_wr_d, wq_rd_q, wq_rd_d;
    logic [WAW:0]   wq_cnt_q, wq_cnt_d;
    logic           wq_full, wq_empty, wq_push, wq_pop;

    state_t         state_q, state_d;
    logic           load_head, strobe;
    logic [7:0]     addr_q, data_q;

    assign wq_full       = (wq_cnt_q == (WAW+1)'(WQ_DEPTH));
    assign wq_empty      = (wq_cnt_q == '0);
    assign host_wr_ready = !wq_full;
    assign wq_push       = host_wr_valid && !wq_full && !clear;

    // Strobe is combinational on the state so a reset mid-issue drops it at once.
    assign strobe = (state_q == S_ISSUE) && dsp_idle && !clear;
    assign wq_pop = strobe;

    assign dsp_reg_write_enable = strobe;
    assign dsp_reg_address      = addr_q;
    assign dsp_reg_data_in      = data_q;

    always_comb begin
        state_d   = state_q;
        load_head = 1'b0;
        case (state_q)
            S_WAIT: begin
                // Uses pre-accept occupancy, so a fresh write waits at least a cycle.
                if (!clear && !wq_empty && dsp_idle) begin
                    state_d   = S_ISSUE;
                    load_head = 1'b1;
                end
            end
            S_ISSUE: begin
                if (clear || strobe) state_d = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_comb begin
        wq_wr_d  = wq_wr_q;
        wq_rd_d  = wq_rd_q;
        wq_cnt_d = wq_cnt_q;
        if (wq_push) wq_wr_d = wq_wr_q + 1'b1;
        if (wq_pop)  wq_rd_d = wq_rd_q + 1'b1;
        case ({wq_push, wq_pop})
            2'b10:   wq_cnt_d = wq_cnt_q + 1'b1;
            2'b01:   wq_cnt_d = wq_cnt_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_WAIT;
            wq_wr_q  <= '0;
            wq_rd_q  <= '0;
            wq_cnt_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
        end else if (clear) begin
            state_q  <= S_WAIT;
            wq_wr_q  <= '0;
            wq_rd_q  <= '0;
            wq_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            wq_wr_q  <= wq_wr_d;
            wq_rd_q  <= wq_rd_d;
            wq_cnt_q <= wq_cnt_d;
            if (load_head) {addr_q, data_q} <= wq_mem[wq_rd_q];
        end
    end

    always_ff @(posedge clock) begin
        if (wq_push) wq_mem[wq_wr_q] <= {host_wr_addr, host_wr_data};
    end

    // ---------------- frame capture FIFO ----------------
    logic [FW-1:0]  cap_mem [CAPTURE_DEPTH];
    logic [CAW-1:0] cap_wr_q, cap_wr_d, cap_rd_q, cap_rd_d;
    logic [CAW:0]   cap_cnt_q, cap_cnt_d;
    logic           idle_q, edge_q;
    logic           cap_full, cap_empty, cap_push, cap_pop, cap_wr_en;
    logic           ovf_q, ovf_d;

    assign cap_full  = (cap_cnt_q == (CAW+1)'(CAPTURE_DEPTH));
    assign cap_empty = (cap_cnt_q == '0);
    assign cap_push  = edge_q && capture_enable && !clear;
    assign cap_pop   = cap_rd_ready && !cap_empty && !clear;
    // A full FIFO still accepts a frame when the head leaves in the same cycle.
    assign cap_wr_en = cap_push && (!cap_full || cap_pop);

    assign cap_rd_valid = !cap_empty;
    assign cap_rd_data  = cap_mem[cap_rd_q];
    assign cap_count    = cap_cnt_q;
    assign cap_overflow = ovf_q;

    always_comb begin
        cap_wr_d  = cap_wr_q;
        cap_rd_d  = cap_rd_q;
        cap_cnt_d = cap_cnt_q;
        ovf_d     = ovf_q | (cap_push && cap_full && !cap_pop);
        if (cap_wr_en) cap_wr_d = cap_wr_q + 1'b1;
        if (cap_pop)   cap_rd_d = cap_rd_q + 1'b1;
        case ({cap_wr_en, cap_pop})
            2'b10:   cap_cnt_d = cap_cnt_q + 1'b1;
            2'b01:   cap_cnt_d = cap_cnt_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idle_q    <= 1'b0;
            edge_q    <= 1'b0;
            cap_wr_q  <= '0;
            cap_rd_q  <= '0;
            cap_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            idle_q <= dsp_idle;
            edge_q <= dsp_idle && !idle_q;
            if (clear) begin
                cap_wr_q  <= '0;
                cap_rd_q  <= '0;
                cap_cnt_q <= '0;
                ovf_q     <= 1'b0;
            end else begin
                cap_wr_q  <= cap_wr_d;
                cap_rd_q  <= cap_rd_d;
                cap_cnt_q <= cap_cnt_d;
                ovf_q     <= ovf_d;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (cap_wr_en) cap_mem[cap_wr_q] <= dac_in;
    end

endmodule

// File: tb/tb_dsp_test_harness.sv
// Bench for dsp_test_harness: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_dsp_test_harness;

    localparam int SW = 16;
    localparam int CH = 2;
    localparam int CD = 64;
    localparam int WD = 8;
    localparam int FW = SW * CH;
    localparam int CW = $clog2(CD) + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          host_wr_valid = 1'b0;
    logic [7:0]    host_wr_addr = '0;
    logic [7:0]    host_wr_data = '0;
    logic          host_wr_ready;
    logic [7:0]    dsp_reg_address;
    logic [7:0]    dsp_reg_data_in;
    logic          dsp_reg_write_enable;
    logic          dsp_idle = 1'b0;
    logic [FW-1:0] dac_in = '0;
    logic          capture_enable = 1'b0;
    logic          cap_rd_valid;
    logic [FW-1:0] cap_rd_data;
    logic          cap_rd_ready = 1'b0;
    logic [CW-1:0] cap_count;
    logic          cap_overflow;
    logic          clear = 1'b0;

    dsp_test_harness #(
        .SAMPLE_WIDTH(SW), .CHANNELS(CH), .CAPTURE_DEPTH(CD), .WQ_DEPTH(WD)
    ) dut (
        .clock(clock), .reset(reset),
        .host_wr_valid(host_wr_valid), .host_wr_addr(host_wr_addr),
        .host_wr_data(host_wr_data), .host_wr_ready(host_wr_ready),
        .dsp_reg_address(dsp_reg_address), .dsp_reg_data_in(dsp_reg_data_in),
        .dsp_reg_write_enable(dsp_reg_write_enable), .dsp_idle(dsp_idle),
        .dac_in(dac_in), .capture_enable(capture_enable),
        .cap_rd_valid(cap_rd_valid), .cap_rd_data(cap_rd_data),
        .cap_rd_ready(cap_rd_ready), .cap_count(cap_count),
        .cap_overflow(cap_overflow), .clear(clear)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Writes: FIFO of {addr,data}; a write is "armed" one cycle after the DSP is
    // seen idle with work pending, and fires in the next idle cycle.
    logic [15:0]   m_wq[$];
    logic [FW-1:0] m_cap[$];
    bit            m_armed = 1'b0;
    bit            m_ovf = 1'b0;
    bit            m_idle_prev = 1'b0;
    bit            m_edge = 1'b0;
    int            cyc = 0;
    bit            mw_we, mw_acc, mc_ev, mc_pop;
    int            mw_sz;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_wq.delete();
            m_cap.delete();
            m_armed     = 1'b0;
            m_ovf       = 1'b0;
            m_idle_prev = 1'b0;
            m_edge      = 1'b0;
        end else begin
            mw_sz  = m_wq.size();
            mw_we  = m_armed && dsp_idle && !clear;
            mw_acc = host_wr_valid && (mw_sz < WD) && !clear;
            mc_ev  = m_edge && capture_enable;
            mc_pop = cap_rd_ready && (m_cap.size() > 0);
            if (clear) begin
                m_armed = 1'b0;
                m_wq.delete();
                m_cap.delete();
                m_ovf = 1'b0;
            end else begin
                m_armed = m_armed ? !mw_we : (mw_sz > 0 && dsp_idle);
                if (mw_we) void'(m_wq.pop_front());
                if (mw_acc) m_wq.push_back({host_wr_addr, host_wr_data});
                if (mc_pop) void'(m_cap.pop_front());
                if (mc_ev) begin
                    if (m_cap.size() < CD) m_cap.push_back(dac_in);
                    else m_ovf = 1'b1;
                end
            end
            m_edge      = dsp_idle && !m_idle_prev;
            m_idle_prev = dsp_idle;
        end
        if (!reset) cyc++;
    end

    // Strobe log used by the directed checks.
    logic [7:0] lg_addr[$];
    logic [7:0] lg_data[$];
    int         lg_cyc[$];

    bit         c_we;
    always @(negedge clock) begin
        c_we = m_armed && dsp_idle && !clear && !reset;
        chk("ready", 64'(host_wr_ready), 64'(m_wq.size() < WD));
        chk("strobe", 64'(dsp_reg_write_enable), 64'(c_we));
        if (c_we && m_wq.size() > 0) begin
            chk("wr_addr", 64'(dsp_reg_address), 64'(m_wq[0][15:8]));
            chk("wr_data", 64'(dsp_reg_data_in), 64'(m_wq[0][7:0]));
        end
        chk("cap_count", 64'(cap_count), 64'(m_cap.size()));
        chk("cap_valid", 64'(cap_rd_valid), 64'(m_cap.size() > 0));
        chk("cap_ovf", 64'(cap_overflow), 64'(m_ovf));
        if (m_cap.size() > 0) chk("cap_data", 64'(cap_rd_data), 64'(m_cap[0]));
        if (dsp_reg_write_enable) begin
            lg_addr.push_back(dsp_reg_address);
            lg_data.push_back(dsp_reg_data_in);
            lg_cyc.push_back(cyc);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] d);
        host_wr_valid = 1'b1;
        host_wr_addr  = a;
        host_wr_data  = d;
        tick();
        host_wr_valid = 1'b0;
    endtask

    // One-cycle idle pulse; the frame is sampled on the following cycle.
    task automatic pulse(input logic [FW-1:0] f, input bit pop);
        dac_in   = f;
        dsp_idle = 1'b1;
        tick();
        dsp_idle     = 1'b0;
        cap_rd_ready = pop;
        tick();
        cap_rd_ready = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int  base;
    bit  got;

    initial begin
        // Reset state
        tick(2);
        chk("rst_ready", 64'(host_wr_ready), 64'd1);
        chk("rst_we", 64'(dsp_reg_write_enable), 64'd0);
        chk("rst_addr", 64'(dsp_reg_address), 64'd0);
        chk("rst_data", 64'(dsp_reg_data_in), 64'd0);
        chk("rst_count", 64'(cap_count), 64'd0);
        chk("rst_valid", 64'(cap_rd_valid), 64'd0);
        chk("rst_ovf", 64'(cap_overflow), 64'd0);
        reset = 1'b0;
        tick();

        // Two writes while idle: issued in order, two cycles apart
        dsp_idle = 1'b1;
        tick();
        base = lg_addr.size();
        push(8'h4C, 8'h01);
        push(8'h5C, 8'h00);
        tick(6);
        chk("t1_nstrobe", 64'(lg_addr.size() - base), 64'd2);
        if (lg_addr.size() >= base + 2) begin
            chk("t1_addr0", 64'(lg_addr[base]), 64'h4C);
            chk("t1_addr1", 64'(lg_addr[base+1]), 64'h5C);
            chk("t1_data0", 64'(lg_data[base]), 64'h01);
            chk("t1_gap", 64'(lg_cyc[base+1] - lg_cyc[base]), 64'd2);
        end

        // Eight writes while busy fill the queue; then drain in order
        dsp_idle = 1'b0;
        tick();
        base = lg_addr.size();
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i), 8'hA0 + 8'(i));
        chk("t2_full_ready", 64'(host_wr_ready), 64'd0);
        push(8'hEE, 8'hEE);
        tick(3);
        chk("t2_stalled", 64'(lg_addr.size() - base), 64'd0);
        dsp_idle = 1'b1;
        tick(20);
        chk("t2_nstrobe", 64'(lg_addr.size() - base), 64'd8);
        for (int i = 0; i < 8; i++)
            if (lg_addr.size() > base + i)
                chk("t2_order", 64'(lg_addr[base+i]), 64'(8'h10 + 8'(i)));
        chk("t2_ready_back", 64'(host_wr_ready), 64'd1);

        // Three captured frames read back in order
        dsp_idle       = 1'b0;
        capture_enable = 1'b1;
        tick();
        pulse(32'hFEDC_1234, 1'b0);
        pulse(32'h0002_0001, 1'b0);
        pulse(32'h0003_0002, 1'b0);
        chk("t3_count", 64'(cap_count), 64'd3);
        chk("t3_frame0", 64'(cap_rd_data), 64'hFEDC_1234);
        chk("t3_ch0", 64'(cap_rd_data[15:0]), 64'h1234);
        cap_rd_ready = 1'b1; tick(); cap_rd_ready = 1'b0;
        chk("t3_frame1", 64'(cap_rd_data), 64'h0002_0001);
        cap_rd_ready = 1'b1; tick(); cap_rd_ready = 1'b0;
        chk("t3_frame2", 64'(cap_rd_data), 64'h0003_0002);
        cap_rd_ready = 1'b1; tick(); cap_rd_ready = 1'b0;
        chk("t3_empty", 64'(cap_rd_valid), 64'd0);
        cap_rd_ready = 1'b1; tick(); cap_rd_ready = 1'b0;
        chk("t3_pop_empty", 64'(cap_count), 64'd0);

        // Fill, overflow, then full with simultaneous capture and pop
        for (int k = 0; k < CD; k++) pulse(32'h1000 + 32'(k), 1'b0);
        chk("t4_count_full", 64'(cap_count), 64'd64);
        chk("t4_no_ovf", 64'(cap_overflow), 64'd0);
        pulse(32'hDEAD_0000, 1'b0);
        chk("t4_count_ovf", 64'(cap_count), 64'd64);
        chk("t4_ovf", 64'(cap_overflow), 64'd1);
        chk("t4_head_kept", 64'(cap_rd_data), 64'h1000);
        pulse(32'hBEEF_0000, 1'b1);
        chk("t4_count_swap", 64'(cap_count), 64'd64);
        chk("t4_head_adv", 64'(cap_rd_data), 64'h1001);
        chk("t4_ovf_sticky", 64'(cap_overflow), 64'd1);

        // Clear beats a same-cycle write, capture and pending strobe
        push(8'h77, 8'h55);
        dac_in   = 32'hCAFE_0000;
        dsp_idle = 1'b1;
        tick();
        base          = lg_addr.size();
        clear         = 1'b1;
        host_wr_valid = 1'b1;
        host_wr_addr  = 8'h99;
        host_wr_data  = 8'h11;
        tick();
        clear         = 1'b0;
        host_wr_valid = 1'b0;
        dsp_idle      = 1'b0;
        tick(5);
        chk("t5_count", 64'(cap_count), 64'd0);
        chk("t5_valid", 64'(cap_rd_valid), 64'd0);
        chk("t5_ovf", 64'(cap_overflow), 64'd0);
        chk("t5_ready", 64'(host_wr_ready), 64'd1);
        chk("t5_no_strobe", 64'(lg_addr.size() - base), 64'd0);

        // Reset during a strobe with writes still queued
        capture_enable = 1'b0;
        for (int i = 0; i < 4; i++) push(8'h21 + 8'(i), 8'h30 + 8'(i));
        dsp_idle = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (dsp_reg_write_enable) got = 1'b1;
        end
        chk("t6_strobe_seen", 64'(got), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("t6_async_we", 64'(dsp_reg_write_enable), 64'd0);
        chk("t6_async_addr", 64'(dsp_reg_address), 64'd0);
        chk("t6_ready", 64'(host_wr_ready), 64'd1);
        base = lg_addr.size();
        tick();
        reset = 1'b0;
        tick(10);
        chk("t6_no_strobe", 64'(lg_addr.size() - base), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
